updown_count_ctrl: RTL and testbench

Run-control sequencer for the board's 4-bit up/down counter datapath. It replaces free-running, delay-paced counting with a clock-enable prescaler, start/stop/hold control, a programmable count window [lo_lim, hi_lim], and either wrap or bounce (ping-pong) at the window edges. The block owns the count register and drives the LED/display count and status flags.

---
 rtl/updown_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/updown_count_ctrl.sv | 143 ++++++++++++++
 tb/tb_updown_count_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// Shared types and defaults for the up/down count run-control block.
package updown_pkg;

    localparam int WIDTH_DEF    = 4;
    localparam int PRESCALE_DEF = 100000000;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// Run-control sequencer owning the windowed up/down count register.
module updown_count_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_in,
    input  logic             bounce_en,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             dir_out,
    output logic             busy,
    output logic             edge_pulse,
    output logic             cfg_err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_busy;
    logic             r_edge;
    logic             r_cfg_err;

    logic             w_run;
    logic             w_tick;
    logic             w_go;
    logic             w_out_win;
    logic             w_flat;
    logic [WIDTH-1:0] w_nxt_cnt;
    logic             w_nxt_dir;
    logic             w_nxt_edge;

    assign w_run = (r_state == RUN);
    assign w_go  = start & ~stop;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (w_run),
        .tick (w_tick)
    );

    assign w_out_win = (r_cnt < lo_lim) || (r_cnt > hi_lim);
    assign w_flat    = (lo_lim == hi_lim);

    // Edges are checked before stepping, so the count never leaves the window.
    always_comb begin
        w_nxt_cnt  = r_cnt;
        w_nxt_dir  = r_dir;
        w_nxt_edge = 1'b0;
        if (w_out_win) begin
            w_nxt_cnt = (r_dir == DIR_UP) ? lo_lim : hi_lim;
        end else if (r_dir == DIR_UP) begin
            if (r_cnt != hi_lim) begin
                w_nxt_cnt = r_cnt + WIDTH'(1);
            end else if (bounce_en) begin
                w_nxt_dir  = DIR_DOWN;
                w_nxt_cnt  = w_flat ? hi_lim : hi_lim - WIDTH'(1);
                w_nxt_edge = 1'b1;
            end else begin
                w_nxt_cnt  = lo_lim;
                w_nxt_edge = 1'b1;
            end
        end else begin
            if (r_cnt != lo_lim) begin
                w_nxt_cnt = r_cnt - WIDTH'(1);
            end else if (bounce_en) begin
                w_nxt_dir  = DIR_UP;
                w_nxt_cnt  = w_flat ? lo_lim : lo_lim + WIDTH'(1);
                w_nxt_edge = 1'b1;
            end else begin
                w_nxt_cnt  = hi_lim;
                w_nxt_edge = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dir     <= DIR_UP;
            r_busy    <= 1'b0;
            r_edge    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (lo_lim > hi_lim);
            r_edge    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_dir   <= dir_in;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (w_go) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A load pre-empts any step landing on the same cycle.
            if (load) begin
                r_cnt <= load_val;
            end else if (w_tick && !r_cfg_err) begin
                r_cnt  <= w_nxt_cnt;
                r_dir  <= w_nxt_dir;
                r_edge <= w_nxt_edge;
            end
        end
    end

    assign cnt        = r_cnt;
    assign dir_out    = r_dir;
    assign busy       = r_busy;
    assign edge_pulse = r_edge;
    assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl with PRESCALE = 4.
module tb_updown_count_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, dir_in, bounce_en, load;
    logic [W-1:0] lo_lim, hi_lim, load_val;
    logic [W-1:0] cnt;
    logic         dir_out, busy, edge_pulse, cfg_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    updown_count_ctrl #(
        .WIDTH(W),
        .PRESCALE(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .dir_in    (dir_in),
        .bounce_en (bounce_en),
        .lo_lim    (lo_lim),
        .hi_lim    (hi_lim),
        .load      (load),
        .load_val  (load_val),
        .cnt       (cnt),
        .dir_out   (dir_out),
        .busy      (busy),
        .edge_pulse(edge_pulse),
        .cfg_err   (cfg_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) step_clk();
    endtask

    int exp_seq  [7] = '{4, 5, 6, 5, 4, 3, 4};
    int exp_dir  [7] = '{1, 1, 1, 0, 0, 0, 1};
    int exp_edge [7] = '{0, 0, 0, 1, 0, 0, 1};

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        dir_in = 1'b1; bounce_en = 1'b0; load = 1'b0;
        lo_lim = 4'd0; hi_lim = 4'd15; load_val = 4'd0;
        #22 rst_n = 1'b1;
        step_clk();
        check("rst_cnt", cnt, 0);
        check("rst_dir", dir_out, 1);
        check("rst_busy", busy, 0);
        check("rst_edge", edge_pulse, 0);
        check("rst_cfg", cfg_err, 0);

        // full-range wrap count
        start = 1'b1;
        step_clk();
        cyc = 0;
        start = 1'b0;
        check("run_busy", busy, 1);
        to_cyc(3);
        check("pre_step", cnt, 0);
        to_cyc(4);
        check("first_step", cnt, 1);
        to_cyc(8);
        check("second_step", cnt, 2);
        to_cyc(60);
        check("at_15", cnt, 15);
        check("no_edge", edge_pulse, 0);
        to_cyc(64);
        check("wrap_cnt", cnt, 0);
        check("wrap_edge", edge_pulse, 1);
        to_cyc(65);
        check("wrap_edge_off", edge_pulse, 0);

        // bounce in [3,6]
        lo_lim = 4'd3; hi_lim = 4'd6; bounce_en = 1'b1;
        load = 1'b1; load_val = 4'd3;
        to_cyc(66);
        load = 1'b0;
        check("load3", cnt, 3);
        for (int i = 0; i < 7; i++) begin
            to_cyc(68 + 4 * i);
            check("bnc_cnt", cnt, exp_seq[i]);
            check("bnc_dir", dir_out, exp_dir[i]);
            check("bnc_edge", edge_pulse, exp_edge[i]);
        end

        // stop 2 clks into a period, hold, resume
        to_cyc(94);
        stop = 1'b1;
        to_cyc(95);
        stop = 1'b0;
        to_cyc(96);
        check("hold_busy", busy, 0);
        to_cyc(100);
        check("hold_cnt", cnt, 4);
        start = 1'b1; stop = 1'b1;
        to_cyc(101);
        start = 1'b0; stop = 1'b0;
        check("hold_both", busy, 0);
        to_cyc(104);
        start = 1'b1; dir_in = 1'b0;
        to_cyc(105);
        start = 1'b0;
        check("resume_busy", busy, 1);
        to_cyc(108);
        check("resume_wait", cnt, 4);
        to_cyc(109);
        check("resume_step", cnt, 5);
        check("resume_dir", dir_out, 1);

        // load on a tick cycle, then out-of-window recovery
        to_cyc(112);
        load = 1'b1; load_val = 4'd9;
        to_cyc(113);
        load = 1'b0;
        check("load_tick", cnt, 9);
        to_cyc(117);
        check("oow_cnt", cnt, 3);
        check("oow_edge", edge_pulse, 0);

        // inverted window freezes the count
        lo_lim = 4'd10; hi_lim = 4'd5;
        to_cyc(118);
        check("cfg_err_on", cfg_err, 1);
        to_cyc(129);
        check("frozen_cnt", cnt, 3);
        check("frozen_dir", dir_out, 1);
        lo_lim = 4'd2;
        to_cyc(130);
        check("cfg_err_off", cfg_err, 0);
        to_cyc(133);
        check("resume_cfg", cnt, 4);

        // asynchronous reset mid-period with cnt = 7
        hi_lim = 4'd15; load = 1'b1; load_val = 4'd7;
        to_cyc(134);
        load = 1'b0;
        check("pre_rst", cnt, 7);
        to_cyc(135);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", cnt, 0);
        check("arst_dir", dir_out, 1);
        check("arst_busy", busy, 0);
        check("arst_edge", edge_pulse, 0);
        check("arst_cfg", cfg_err, 0);
        step_clk();
        step_clk();
        #2 rst_n = 1'b1;
        to_cyc(cyc + 8);
        check("idle_busy", busy, 0);
        check("idle_cnt", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
